// File: rtl/uart_frame_parser.sv
// Frame parser for the UART receive path: HDR0 HDR1 CMD LEN PAYLOAD[LEN] CSUM.
// Streams payload bytes out as they arrive and flags each frame as good or bad.
module uart_frame_parser #(
    parameter logic [7:0] HDR0        = 8'hAA,
    parameter logic [7:0] HDR1        = 8'h55,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] data_byte,
    output logic       pld_we,
    output logic [7:0] pld_addr,
    output logic [7:0] pld_data,
    output logic       frame_valid,
    output logic [7:0] frame_cmd,
    output logic [7:0] frame_len,
    output logic       csum_err,
    output logic       len_err,
    output logic       timeout_err,
    output logic [2:0] fsm_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_H1  = 3'd1;
    localparam logic [2:0] GET_CMD  = 3'd2;
    localparam logic [2:0] GET_LEN  = 3'd3;
    localparam logic [2:0] DATA     = 3'd4;
    localparam logic [2:0] GET_CSUM = 3'd5;

    localparam int         TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] MAX_L   = 8'(MAX_LEN);

    logic [2:0]    state;
    logic [7:0]    cmd_q;
    logic [7:0]    len_q;
    logic [7:0]    idx_q;
    logic [7:0]    sum_q;
    logic [TW-1:0] timer_q;

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_q       <= 8'd0;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            sum_q       <= 8'd0;
            timer_q     <= '0;
            pld_we      <= 1'b0;
            pld_addr    <= 8'd0;
            pld_data    <= 8'd0;
            frame_valid <= 1'b0;
            frame_cmd   <= 8'd0;
            frame_len   <= 8'd0;
            csum_err    <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pld_we      <= 1'b0;
            frame_valid <= 1'b0;
            csum_err    <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;

            if (rx_done) begin
                // A byte arriving on the expiry cycle still counts; the timer just restarts.
                timer_q <= '0;
                case (state)
                    IDLE: begin
                        if (data_byte == HDR0) state <= WAIT_H1;
                    end
                    WAIT_H1: begin
                        if (data_byte == HDR1)      state <= GET_CMD;
                        else if (data_byte != HDR0) state <= IDLE;
                    end
                    GET_CMD: begin
                        cmd_q <= data_byte;
                        sum_q <= data_byte;
                        state <= GET_LEN;
                    end
                    GET_LEN: begin
                        if (data_byte > MAX_L) begin
                            len_err <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            len_q <= data_byte;
                            idx_q <= 8'd0;
                            sum_q <= sum_q + data_byte;
                            state <= (data_byte == 8'd0) ? GET_CSUM : DATA;
                        end
                    end
                    DATA: begin
                        pld_we   <= 1'b1;
                        pld_addr <= idx_q;
                        pld_data <= data_byte;
                        sum_q    <= sum_q + data_byte;
                        idx_q    <= idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) state <= GET_CSUM;
                    end
                    GET_CSUM: begin
                        if (data_byte == sum_q) begin
                            frame_valid <= 1'b1;
                            frame_cmd   <= cmd_q;
                            frame_len   <= len_q;
                        end else begin
                            csum_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (timer_q == T_LAST) begin
                    timeout_err <= 1'b1;
                    timer_q     <= '0;
                    state       <= IDLE;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end else begin
                timer_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomised bench for uart_frame_parser: a byte-queue reference model predicts
// an ordered event stream that a negedge monitor checks against the DUT outputs.
module tb_uart_frame_parser;

    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;
    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 40;

    localparam logic [3:0] EV_WR  = 4'd1;
    localparam logic [3:0] EV_OK  = 4'd2;
    localparam logic [3:0] EV_CS  = 4'd3;
    localparam logic [3:0] EV_LEN = 4'd4;
    localparam logic [3:0] EV_TO  = 4'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] data_byte;
    logic       pld_we;
    logic [7:0] pld_addr;
    logic [7:0] pld_data;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       csum_err;
    logic       len_err;
    logic       timeout_err;
    logic [2:0] fsm_state;

    uart_frame_parser #(
        .HDR0(HDR0), .HDR1(HDR1), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .data_byte(data_byte),
        .pld_we(pld_we), .pld_addr(pld_addr), .pld_data(pld_data),
        .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
        .csum_err(csum_err), .len_err(len_err), .timeout_err(timeout_err),
        .fsm_state(fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [19:0] exp_q[$];

    // Reference model: header progress, then the frame body collected in a queue.
    int         hdr_seen = 0;
    logic [7:0] body[$];
    int         gap = 0;
    logic [7:0] m_cmd = 8'd0;
    logic [7:0] m_len = 8'd0;

    task automatic model_reset();
        hdr_seen = 0;
        body.delete();
        gap   = 0;
        m_cmd = 8'd0;
        m_len = 8'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        int s;
        gap = 0;
        if (hdr_seen == 0) begin
            if (b == HDR0) hdr_seen = 1;
        end else if (hdr_seen == 1) begin
            if (b == HDR1) begin
                hdr_seen = 2;
                body.delete();
            end else if (b != HDR0) begin
                hdr_seen = 0;
            end
        end else begin
            body.push_back(b);
            n = body.size();
            if (n == 2 && int'(b) > MAX_LEN) begin
                exp_q.push_back({EV_LEN, m_cmd, m_len});
                hdr_seen = 0;
            end else if (n >= 3 && n <= int'(body[1]) + 2) begin
                exp_q.push_back({EV_WR, 8'(n - 3), b});
            end else if (n >= 3 && n == int'(body[1]) + 3) begin
                s = 0;
                for (int i = 0; i < n - 1; i++) s += int'(body[i]);
                if (8'(s % 256) == b) begin
                    m_cmd = body[0];
                    m_len = body[1];
                    exp_q.push_back({EV_OK, m_cmd, m_len});
                end else begin
                    exp_q.push_back({EV_CS, m_cmd, m_len});
                end
                hdr_seen = 0;
            end
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic idle(input int n);
        if (hdr_seen != 0 && gap < TIMEOUT_CYC && gap + n >= TIMEOUT_CYC) begin
            exp_q.push_back({EV_TO, m_cmd, m_len});
            hdr_seen = 0;
        end
        gap += n;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        rx_done   = 1'b1;
        data_byte = b;
        @(posedge clk);
        #1;
        rx_done   = 1'b0;
        data_byte = $urandom_range(0, 255);
    endtask

    task automatic send_gap(input logic [7:0] b, input int gap_max);
        send(b);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                              input bit bad_csum, input int gap_max);
        int s;
        logic [7:0] p;
        s = int'(cmd) + int'(len);
        send_gap(HDR0, gap_max);
        send_gap(HDR1, gap_max);
        send_gap(cmd, gap_max);
        send_gap(len, gap_max);
        for (int i = 0; i < int'(len); i++) begin
            p = $urandom_range(0, 255);
            s += int'(p);
            send_gap(p, gap_max);
        end
        send_gap(bad_csum ? 8'(s % 256) ^ 8'h5A : 8'(s % 256), gap_max);
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every DUT output event must match the head of exp_q.
    task automatic take_event(input logic [19:0] obs);
        logic [19:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event got %h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                n_fail++;
                $display("FAIL event got %h expected %h", obs, e);
            end
        end
    endtask

    always @(negedge clk) begin
        int pulses;
        if (rst === 1'b0) begin
            pulses = int'(frame_valid) + int'(csum_err) + int'(len_err) + int'(timeout_err);
            if (pld_we)      take_event({EV_WR, pld_addr, pld_data});
            if (frame_valid) take_event({EV_OK, frame_cmd, frame_len});
            if (csum_err)    take_event({EV_CS, frame_cmd, frame_len});
            if (len_err)     take_event({EV_LEN, frame_cmd, frame_len});
            if (timeout_err) take_event({EV_TO, frame_cmd, frame_len});
            if (pulses > 0) begin
                n_cmp++;
                if (pulses > 1) begin
                    n_fail++;
                    $display("FAIL pulse_exclusive got %0d pulses expected 1", pulses);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check_val("rst_pld_we",   8'(pld_we), 8'd0);
        check_val("rst_pld_addr", pld_addr, 8'd0);
        check_val("rst_pld_data", pld_data, 8'd0);
        check_val("rst_valid",    8'(frame_valid), 8'd0);
        check_val("rst_cmd",      frame_cmd, 8'd0);
        check_val("rst_len",      frame_len, 8'd0);
        check_val("rst_errs",     {5'd0, csum_err, len_err, timeout_err}, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        idle(3);
        check_reset_outputs();
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        rx_done   = 1'b0;
        data_byte = 8'd0;
        rst       = 1'b0;
        #1;
        do_reset();

        // Directed: good frame, bad checksum, repeated header + LEN 0, LEN too big.
        send(8'hAA); send(8'h55); send(8'h10); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03); send(8'h19);
        idle(2);
        send(8'hAA); send(8'h55); send(8'h10); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03); send(8'h18);
        idle(2);
        send(8'hAA); send(8'hAA); send(8'h55); send(8'h20); send(8'h00); send(8'h20);
        idle(2);
        send(8'hAA); send(8'h55); send(8'h20); send(8'h11);
        idle(2);
        send(MAX_LEN == 16 ? 8'hAA : 8'h00);
        send(8'h55); send(8'h30); send(8'(MAX_LEN));
        for (int i = 0; i < MAX_LEN; i++) send(8'(i));
        send(8'(8'h30 + 8'(MAX_LEN) + 8'(MAX_LEN * (MAX_LEN - 1) / 2)));
        idle(2);

        // Timeout, then the byte-wins boundary one cycle short of expiry.
        send(8'hAA); send(8'h55); send(8'h10); send(8'h03); send(8'h01);
        idle(TIMEOUT_CYC);
        idle(2);
        send_frame(8'h42, 8'd2, 1'b0, 0);
        send(8'hAA); idle(TIMEOUT_CYC - 1); send(8'h55); send(8'h07);
        idle(TIMEOUT_CYC - 1); send(8'h00); send(8'h07);
        idle(2);

        // Reset mid-payload, then a clean frame.
        send(8'hAA); send(8'h55); send(8'h33); send(8'h04); send(8'h09);
        idle(2);
        do_reset();
        send_frame(8'h77, 8'd5, 1'b0, 0);
        idle(2);

        // Back-to-back frames with rx_done every clock.
        for (int i = 0; i < 4; i++) send_frame($urandom_range(0, 255), $urandom_range(0, MAX_LEN), 1'b0, 0);
        idle(2);

        // Random mix of traffic.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1: send_frame($urandom_range(0, 255), $urandom_range(0, MAX_LEN), 1'b0, 2);
                2: send_frame($urandom_range(0, 255), $urandom_range(0, MAX_LEN), 1'b1, 1);
                3: begin
                    send_gap(HDR0, 1); send_gap(HDR1, 1); send_gap($urandom_range(0, 255), 1);
                    send_gap($urandom_range(MAX_LEN + 1, 255), 1);
                end
                4: for (int j = 0; j < int'($urandom_range(1, 4)); j++) send_gap($urandom_range(0, 255), 2);
                5: begin
                    send(HDR0); send(HDR1); send($urandom_range(0, 255));
                    idle($urandom_range(TIMEOUT_CYC - 1, TIMEOUT_CYC + 3));
                end
                default: send_frame($urandom_range(0, 255), $urandom_range(0, MAX_LEN), 1'b0, 0);
            endcase
        end
        idle(TIMEOUT_CYC + 5);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
